// File: rtl/to_master_mailbox.sv
// ---------------------------------------------------------------------------
// to_master_mailbox
//
// Nios-to-ARM message mailbox. The Nios (writer port) pushes 32-bit message
// words into a circular FIFO. A level interrupt tells the HPS master that
// messages are waiting. The HPS (reader port) pops words and then
// acknowledges the interrupt. A hold-off timer limits how fast the
// interrupt can re-assert after an ack.
//
// Parameters:
//   DEPTH    FIFO depth in words (power of 2, 2..128)
//   HOLDOFF  minimum cycles irq stays low after an ack (0 = no hold-off)
//
// Ports:
//   clk_clk        in   1   single clock for all logic
//   reset_reset    in   1   synchronous active-high reset
//   wr_address     in   2   writer register select
//   wr_write       in   1   writer write strobe
//   wr_writedata   in  32   writer write data
//   wr_read        in   1   writer read strobe
//   wr_readdata    out 32   writer read data, registered (latency 1)
//   rd_address     in   2   reader register select
//   rd_read        in   1   reader read strobe
//   rd_readdata    out 32   reader read data, registered (latency 1)
//   rd_write       in   1   reader write strobe
//   rd_writedata   in  32   reader write data
//   to_master_irq  out  1   level interrupt to the HPS
//
// STATUS word: [0] empty, [1] full, [2] overflow, [3] underflow,
//              [4] irq_enable, [5] to_master_irq, [15:8] count.
// ---------------------------------------------------------------------------
module to_master_mailbox #(
    parameter int DEPTH   = 16,
    parameter int HOLDOFF = 64
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [1:0]  wr_address,
    input  logic        wr_write,
    input  logic [31:0] wr_writedata,
    input  logic        wr_read,
    output logic [31:0] wr_readdata,
    input  logic [1:0]  rd_address,
    input  logic        rd_read,
    output logic [31:0] rd_readdata,
    input  logic        rd_write,
    input  logic [31:0] rd_writedata,
    output logic        to_master_irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERTED,
        ST_HOLDOFF
    } irqState_t;

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;
    logic          r_irqEnable;
    logic          r_overflow;
    logic          r_underflow;
    logic [31:0]   r_wrReadData;
    logic [31:0]   r_rdReadData;
    irqState_t     r_state;
    logic [HW-1:0] r_holdCnt;
    logic          r_irq;

    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_popEmpty;
    logic          w_pushFull;
    logic          w_ack;
    logic          w_ctrlWrite;
    logic          w_clrOverflow;
    logic          w_clrUnderflow;
    logic [31:0]   w_status;
    logic [31:0]   w_freeSlots;
    logic          w_unusedRdData;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == DEPTH_C);

    // A pop only happens on a non-empty FIFO; a same-cycle pop frees a slot
    // so a push into a full FIFO is still accepted (no bypass of an empty one).
    assign w_pop      = rd_read && (rd_address == 2'd0) && !w_empty;
    assign w_popEmpty = rd_read && (rd_address == 2'd0) && w_empty;
    assign w_push     = wr_write && (wr_address == 2'd0) && (!w_full || w_pop);
    assign w_pushFull = wr_write && (wr_address == 2'd0) && w_full && !w_pop;

    assign w_ctrlWrite    = wr_write && (wr_address == 2'd1);
    assign w_clrOverflow  = w_ctrlWrite && wr_writedata[1];
    assign w_ack          = rd_write && (rd_address == 2'd2) && rd_writedata[0];
    assign w_clrUnderflow = rd_write && (rd_address == 2'd2) && rd_writedata[1];

    assign w_unusedRdData = ^rd_writedata[31:2];

    assign w_status    = {16'h0000, 8'(r_count), 2'b00, r_irq, r_irqEnable,
                          r_underflow, r_overflow, w_full, w_empty};
    assign w_freeSlots = 32'(DEPTH_C - r_count);

    // Message storage; contents need no reset because the pointers and
    // count define what is valid.
    always_ff @(posedge clk_clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= wr_writedata;
        end
    end

    // FIFO pointers, occupancy, control and sticky error flags. Sticky set
    // takes priority over a same-cycle clear.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_count     <= '0;
            r_irqEnable <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_ctrlWrite) begin
                r_irqEnable <= wr_writedata[0];
            end
            if (w_pushFull) begin
                r_overflow <= 1'b1;
            end else if (w_clrOverflow) begin
                r_overflow <= 1'b0;
            end
            if (w_popEmpty) begin
                r_underflow <= 1'b1;
            end else if (w_clrUnderflow) begin
                r_underflow <= 1'b0;
            end
        end
    end

    // Registered read data for both ports. Values are sampled from the
    // current state, so STATUS shows the state before this cycle's updates,
    // and each port holds its last result until its next read.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_wrReadData <= '0;
            r_rdReadData <= '0;
        end else begin
            if (wr_read) begin
                case (wr_address)
                    2'd0:    r_wrReadData <= w_freeSlots;
                    2'd1:    r_wrReadData <= w_status;
                    default: r_wrReadData <= '0;
                endcase
            end
            if (rd_read) begin
                case (rd_address)
                    2'd0:    r_rdReadData <= w_empty ? 32'h0 : r_mem[r_rdPtr];
                    2'd1:    r_rdReadData <= w_status;
                    default: r_rdReadData <= '0;
                endcase
            end
        end
    end

    // Interrupt state machine. Once asserted, irq stays high even if the
    // FIFO drains; only an ack or a disable drops it, and disable wins over
    // a same-cycle ack. The hold-off counter keeps running even if the
    // enable is cleared while it counts.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state   <= ST_IDLE;
            r_holdCnt <= '0;
            r_irq     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_irqEnable && !w_empty) begin
                        r_state <= ST_ASSERTED;
                        r_irq   <= 1'b1;
                    end else begin
                        r_irq   <= 1'b0;
                    end
                end
                ST_ASSERTED: begin
                    if (!r_irqEnable) begin
                        r_state <= ST_IDLE;
                        r_irq   <= 1'b0;
                    end else if (w_ack) begin
                        r_irq <= 1'b0;
                        if (HOLDOFF == 0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state   <= ST_HOLDOFF;
                            r_holdCnt <= HW'(HOLDOFF - 1);
                        end
                    end else begin
                        r_irq <= 1'b1;
                    end
                end
                ST_HOLDOFF: begin
                    r_irq <= 1'b0;
                    if (r_holdCnt == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_holdCnt <= r_holdCnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_irq   <= 1'b0;
                end
            endcase
        end
    end

    assign wr_readdata   = r_wrReadData;
    assign rd_readdata   = r_rdReadData;
    assign to_master_irq = r_irq;

endmodule

// File: tb/tb_to_master_mailbox.sv
// ---------------------------------------------------------------------------
// tb_to_master_mailbox
//
// Self-checking bench for to_master_mailbox (DEPTH=16, HOLDOFF=64).
// A table of single-cycle bus operations with expected read data and irq
// level covers the basic register map; hand-written sequences cover the
// hold-off timing, overflow/underflow, simultaneous push/pop on a full FIFO
// and reset in mid-operation.
// ---------------------------------------------------------------------------
module tb_to_master_mailbox;

    typedef enum logic [1:0] {
        OP_WWR,
        OP_WRD,
        OP_RWR,
        OP_RRD
    } opType_t;

    typedef struct {
        opType_t     op;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [31:0] expData;
        logic        expIrq;
    } vec_t;

    logic        clk_clk;
    logic        reset_reset;
    logic [1:0]  wr_address;
    logic        wr_write;
    logic [31:0] wr_writedata;
    logic        wr_read;
    logic [31:0] wr_readdata;
    logic [1:0]  rd_address;
    logic        rd_read;
    logic [31:0] rd_readdata;
    logic        rd_write;
    logic [31:0] rd_writedata;
    logic        to_master_irq;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    to_master_mailbox #(.DEPTH(16), .HOLDOFF(64)) dut (
        .clk_clk       (clk_clk),
        .reset_reset   (reset_reset),
        .wr_address    (wr_address),
        .wr_write      (wr_write),
        .wr_writedata  (wr_writedata),
        .wr_read       (wr_read),
        .wr_readdata   (wr_readdata),
        .rd_address    (rd_address),
        .rd_read       (rd_read),
        .rd_readdata   (rd_readdata),
        .rd_write      (rd_write),
        .rd_writedata  (rd_writedata),
        .to_master_irq (to_master_irq)
    );

    // Free-running clock.
    initial begin
        clk_clk = 1'b0;
        forever #5 clk_clk = ~clk_clk;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one bus operation for exactly one clock, then release strobes.
    // Returns #1 after the edge, where registered read data is valid.
    task automatic applyStimulus(input opType_t op, input logic [1:0] addr,
                                 input logic [31:0] data);
        case (op)
            OP_WWR: begin wr_address = addr; wr_writedata = data; wr_write = 1'b1; end
            OP_WRD: begin wr_address = addr; wr_read = 1'b1; end
            OP_RWR: begin rd_address = addr; rd_writedata = data; rd_write = 1'b1; end
            default: begin rd_address = addr; rd_read = 1'b1; end
        endcase
        @(posedge clk_clk);
        #1;
        wr_write = 1'b0;
        wr_read  = 1'b0;
        rd_write = 1'b0;
        rd_read  = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic idleCycle();
        @(posedge clk_clk);
        #1;
    endtask

    initial begin
        int lowBad;

        reset_reset  = 1'b1;
        wr_address   = 2'd0;
        wr_write     = 1'b0;
        wr_writedata = 32'h0;
        wr_read      = 1'b0;
        rd_address   = 2'd0;
        rd_read      = 1'b0;
        rd_write     = 1'b0;
        rd_writedata = 32'h0;

        // Basic register map vectors: {op, addr, data, expData, expIrq}.
        vecs.push_back('{OP_WRD, 2'd1, 32'h0,        32'h0000_0001, 1'b0});
        vecs.push_back('{OP_WRD, 2'd0, 32'h0,        32'h0000_0010, 1'b0});
        vecs.push_back('{OP_WWR, 2'd1, 32'h1,        32'h0,         1'b0});
        vecs.push_back('{OP_WWR, 2'd0, 32'hA5A50001, 32'h0,         1'b0});
        vecs.push_back('{OP_WWR, 2'd0, 32'hA5A50002, 32'h0,         1'b1});
        vecs.push_back('{OP_RRD, 2'd1, 32'h0,        32'h0000_0230, 1'b1});
        vecs.push_back('{OP_RRD, 2'd0, 32'h0,        32'hA5A50001,  1'b1});
        vecs.push_back('{OP_RRD, 2'd0, 32'h0,        32'hA5A50002,  1'b1});
        vecs.push_back('{OP_RRD, 2'd1, 32'h0,        32'h0000_0031, 1'b1});
        vecs.push_back('{OP_WRD, 2'd2, 32'h0,        32'h0,         1'b1});
        vecs.push_back('{OP_RRD, 2'd3, 32'h0,        32'h0,         1'b1});
        vecs.push_back('{OP_RWR, 2'd2, 32'h1,        32'h0,         1'b0});

        repeat (2) idleCycle();
        reset_reset = 1'b0;

        checkOutput("reset irq", {31'h0, to_master_irq}, 32'h0);
        checkOutput("reset wr_readdata", wr_readdata, 32'h0);
        checkOutput("reset rd_readdata", rd_readdata, 32'h0);

        $display("[TB] running %0d table vectors", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].op, vecs[i].addr, vecs[i].data);
            if (vecs[i].op == OP_WRD) begin
                checkOutput($sformatf("vec%0d wr_readdata", i), wr_readdata, vecs[i].expData);
            end else if (vecs[i].op == OP_RRD) begin
                checkOutput($sformatf("vec%0d rd_readdata", i), rd_readdata, vecs[i].expData);
            end
            checkOutput($sformatf("vec%0d irq", i), {31'h0, to_master_irq},
                        {31'h0, vecs[i].expIrq});
        end

        // Hold-off: ack was applied by the last vector; push right away.
        // Irq must stay low through 64 cycles of hold-off plus the IDLE
        // cycle, then rise.
        applyStimulus(OP_WWR, 2'd0, 32'hC0DE0001);
        lowBad = 0;
        if (to_master_irq !== 1'b0) lowBad++;
        for (int c = 0; c < 63; c++) begin
            idleCycle();
            if (to_master_irq !== 1'b0) lowBad++;
        end
        checkOutput("holdoff irq low cycles", 32'(lowBad), 32'h0);
        idleCycle();
        checkOutput("holdoff irq rises", {31'h0, to_master_irq}, 32'h1);

        // Disable irq and drain the single word.
        applyStimulus(OP_WWR, 2'd1, 32'h0);
        applyStimulus(OP_RRD, 2'd0, 32'h0);
        checkOutput("holdoff word", rd_readdata, 32'hC0DE0001);
        checkOutput("disable irq", {31'h0, to_master_irq}, 32'h0);

        // Overflow: 17 pushes into a 16-deep FIFO.
        for (int k = 1; k <= 17; k++) begin
            applyStimulus(OP_WWR, 2'd0, 32'h1000_0000 + 32'(k));
        end
        applyStimulus(OP_WRD, 2'd1, 32'h0);
        checkOutput("overflow status", wr_readdata, 32'h0000_1006);
        applyStimulus(OP_WRD, 2'd0, 32'h0);
        checkOutput("full free slots", wr_readdata, 32'h0);
        applyStimulus(OP_WWR, 2'd1, 32'h3);
        applyStimulus(OP_RRD, 2'd1, 32'h0);
        checkOutput("overflow cleared status", rd_readdata, 32'h0000_1012);
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(OP_RRD, 2'd0, 32'h0);
            checkOutput($sformatf("pop word %0d", k), rd_readdata, 32'h1000_0000 + 32'(k));
        end
        rd_address = 2'd0;
        applyStimulus(OP_RRD, 2'd0, 32'h0);
        checkOutput("underflow pop data", rd_readdata, 32'h0);
        applyStimulus(OP_RRD, 2'd1, 32'h0);
        checkOutput("underflow status", rd_readdata, 32'h0000_0039);
        applyStimulus(OP_RWR, 2'd2, 32'h2);
        applyStimulus(OP_RRD, 2'd1, 32'h0);
        checkOutput("underflow cleared status", rd_readdata, 32'h0000_0031);

        // Full FIFO with same-cycle push and pop.
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(OP_WWR, 2'd0, 32'h2000_0000 + 32'(k));
        end
        wr_address   = 2'd0;
        wr_writedata = 32'hDEADBEEF;
        wr_write     = 1'b1;
        rd_address   = 2'd0;
        rd_read      = 1'b1;
        idleCycle();
        wr_write = 1'b0;
        rd_read  = 1'b0;
        checkOutput("simultaneous pop data", rd_readdata, 32'h2000_0001);
        applyStimulus(OP_RRD, 2'd1, 32'h0);
        checkOutput("simultaneous status", rd_readdata, 32'h0000_1032);
        for (int k = 2; k <= 16; k++) begin
            applyStimulus(OP_RRD, 2'd0, 32'h0);
            checkOutput($sformatf("full pop word %0d", k), rd_readdata, 32'h2000_0000 + 32'(k));
        end
        applyStimulus(OP_RRD, 2'd0, 32'h0);
        checkOutput("last pop deadbeef", rd_readdata, 32'hDEADBEEF);

        // Reset in mid-operation with words queued and irq high.
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(OP_WWR, 2'd0, 32'h3000_0000 + 32'(k));
        end
        checkOutput("pre-reset irq", {31'h0, to_master_irq}, 32'h1);
        reset_reset = 1'b1;
        idleCycle();
        reset_reset = 1'b0;
        checkOutput("mid reset irq", {31'h0, to_master_irq}, 32'h0);
        checkOutput("mid reset rd_readdata", rd_readdata, 32'h0);
        applyStimulus(OP_WRD, 2'd1, 32'h0);
        checkOutput("mid reset status", wr_readdata, 32'h0000_0001);
        applyStimulus(OP_WRD, 2'd0, 32'h0);
        checkOutput("mid reset free slots", wr_readdata, 32'h0000_0010);
        idleCycle();
        checkOutput("post reset irq stays low", {31'h0, to_master_irq}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
